// File: rtl/myproject_mac_pkg.sv
// Shared widths, constants and arithmetic helpers
// for the MAC accumulate / ReLU consumer.
package myproject_mac_pkg;

  localparam int PROD_WIDTH  = 11;
  localparam int BIAS_WIDTH  = 11;
  localparam int ACC_WIDTH   = 18;
  localparam int SHIFT       = 4;
  localparam int OUT_WIDTH   = 8;
  localparam int MUL_LATENCY = 4;

  // one guard bit so a single add never wraps before saturation
  localparam int SUM_WIDTH = ACC_WIDTH + 1;

  typedef logic signed [PROD_WIDTH-1:0] prod_t;
  typedef logic signed [BIAS_WIDTH-1:0] bias_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [SUM_WIDTH-1:0]  sum_t;
  typedef logic        [OUT_WIDTH-1:0]  act_t;

  localparam sum_t ACC_MAX = sum_t'((1 << (ACC_WIDTH - 1)) - 1);
  localparam sum_t ACC_MIN = sum_t'(-(1 << (ACC_WIDTH - 1)));
  localparam sum_t ROUND_C = sum_t'(1 << (SHIFT - 1));
  localparam sum_t OUT_MAX = sum_t'((1 << OUT_WIDTH) - 1);

  // clamp a guarded sum into the accumulator range
  function automatic acc_t sat_acc(input sum_t x);
    acc_t r;
    if (x > ACC_MAX) begin
      r = acc_t'(ACC_MAX);
    end else if (x < ACC_MIN) begin
      r = acc_t'(ACC_MIN);
    end else begin
      r = acc_t'(x);
    end
    return r;
  endfunction

  // round-half-up shift, then ReLU and unsigned clamp
  function automatic act_t requant(input acc_t a);
    sum_t t;
    act_t r;
    t = sum_t'(a) + ROUND_C;
    t = t >>> SHIFT;
    if (t < 0) begin
      r = '0;
    end else if (t > OUT_MAX) begin
      r = '1;
    end else begin
      r = t[OUT_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mac_accum_relu_if.sv
// Issue side, product/bias inputs and the
// activation valid/ready port of the neuron unit.
interface myproject_mac_accum_relu_if;
  import myproject_mac_pkg::*;

  logic  ce;
  logic  in_issue;
  logic  in_last;
  logic  in_ready;
  prod_t prod;
  bias_t bias;
  act_t  out_data;
  logic  out_valid;
  logic  out_ready;

  modport master (
    output ce,
    output in_issue,
    output in_last,
    output prod,
    output bias,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  ce,
    input  in_issue,
    input  in_last,
    input  prod,
    input  bias,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/myproject_mac_out_fifo.sv
// Two-entry result buffer; push and pop together
// while full is allowed and keeps the count.
module myproject_mac_out_fifo
  import myproject_mac_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  act_t din,
  input  logic pop,
  output act_t dout,
  output logic empty
);

  act_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       do_pop;
  logic       do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // credits upstream make a push into a full buffer impossible
  assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop))
    else $error("out_fifo overflow");

endmodule

// File: rtl/myproject_mac_accum_relu.sv
// Dense-layer neuron: accumulate products, add bias,
// requantise, ReLU/saturate, buffer with credits.
module myproject_mac_accum_relu
  import myproject_mac_pkg::*;
(
  input logic clk,
  input logic reset,
  myproject_mac_accum_relu_if.slave bus
);

  logic [MUL_LATENCY-1:0] v_dl;
  logic [MUL_LATENCY-1:0] l_dl;
  logic       v_a;
  logic       l_a;
  logic       issue_ok;
  logic       first;
  acc_t       acc;
  acc_t       sum;
  acc_t       biased;
  act_t       act;
  logic       push;
  logic [1:0] cnt;
  logic       inc;
  logic       dec;
  act_t       fifo_dout;
  logic       fifo_empty;

  assign issue_ok = bus.in_issue & bus.in_ready;
  assign v_a      = v_dl[MUL_LATENCY-1];
  assign l_a      = l_dl[MUL_LATENCY-1];
  assign push     = bus.ce & v_a & l_a;

  // track which multiplier outputs are real, aligned to prod
  always_ff @(posedge clk) begin
    if (reset) begin
      v_dl <= '0;
      l_dl <= '0;
    end else if (bus.ce) begin
      v_dl <= {v_dl[MUL_LATENCY-2:0], issue_ok};
      l_dl <= {l_dl[MUL_LATENCY-2:0], issue_ok & bus.in_last};
    end
  end

  // running sum, bias add and activation of the arriving product
  always_comb begin
    sum_t base;
    sum_t raw;
    base   = first ? '0 : sum_t'(acc);
    raw    = base + sum_t'(bus.prod);
    sum    = sat_acc(raw);
    raw    = sum_t'(sum) + sum_t'(bus.bias);
    biased = sat_acc(raw);
    act    = requant(biased);
  end

  // accumulator holds partial sums; last product restarts the neuron
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (bus.ce && v_a) begin
      if (l_a) begin
        first <= 1'b1;
      end else begin
        acc   <= sum;
        first <= 1'b0;
      end
    end
  end

  assign inc = bus.ce & bus.in_issue & bus.in_last & bus.in_ready;
  assign dec = ~fifo_empty & bus.out_ready;

  // credits: neurons in flight plus results waiting in the buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      unique case ({inc, dec})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.in_ready = (cnt < 2'd2);

  myproject_mac_out_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (act),
    .pop   (bus.out_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_dout;

endmodule

// File: tb/tb_myproject_mac_accum_relu.sv
// Directed bench for the neuron accumulator with a
// behavioural 4-stage multiplier feeding prod.
module tb_myproject_mac_accum_relu;
  import myproject_mac_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;

  prod_t din;
  prod_t pipe [MUL_LATENCY];

  myproject_mac_accum_relu_if bus ();

  myproject_mac_accum_relu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: fixed latency, no reset, advances on ce
  always @(posedge clk) begin
    if (bus.ce) begin
      pipe[0] <= din;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.prod = pipe[MUL_LATENCY-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int p, input logic l);
    bus.in_issue = 1'b1;
    bus.in_last  = l;
    din          = prod_t'(p);
    step();
    bus.in_issue = 1'b0;
    bus.in_last  = 1'b0;
    din          = '0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.ce        = 1'b1;
    bus.in_issue  = 1'b0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    din           = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_ready", int'(bus.in_ready), 1);

    // 1: 10+20+30+40 = 100 -> 6
    issue(10, 1'b0);
    issue(20, 1'b0);
    issue(30, 1'b0);
    issue(40, 1'b1);
    wait_valid(n);
    check("t1_lat", n, 4);
    check("t1_data", int'(bus.out_data), 6);
    step();
    check("t1_pop", int'(bus.out_valid), 0);

    // 2a: negative sum -> ReLU 0
    issue(-50, 1'b0);
    issue(-60, 1'b1);
    wait_valid(n);
    check("t2a_lat", n, 4);
    check("t2a_data", int'(bus.out_data), 0);
    step();

    // 2b: 10 + bias 200 -> 13
    bus.bias = bias_t'(200);
    issue(10, 1'b1);
    wait_valid(n);
    check("t2b_lat", n, 4);
    check("t2b_data", int'(bus.out_data), 13);
    step();

    // 3: 16*1023 + 1023 -> 1087 -> 255
    bus.bias = bias_t'(1023);
    for (int i = 0; i < 16; i++) begin
      issue(1023, i == 15);
    end
    wait_valid(n);
    check("t3_lat", n, 4);
    check("t3_data", int'(bus.out_data), 255);
    step();
    bus.bias = '0;

    // 4: back-pressure, credits run out after two neurons
    bus.out_ready = 1'b0;
    issue(32, 1'b1);
    check("t4_rdy1", int'(bus.in_ready), 1);
    issue(48, 1'b1);
    check("t4_rdy2", int'(bus.in_ready), 0);
    issue(64, 1'b1);
    repeat (8) step();
    check("t4_valid", int'(bus.out_valid), 1);
    check("t4_d0", int'(bus.out_data), 2);
    check("t4_rdy3", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    step();
    check("t4_d1", int'(bus.out_data), 3);
    check("t4_v1", int'(bus.out_valid), 1);
    check("t4_rdy4", int'(bus.in_ready), 1);
    step();
    check("t4_empty", int'(bus.out_valid), 0);
    repeat (6) step();
    check("t4_nostale", int'(bus.out_valid), 0);
    check("t4_rdy5", int'(bus.in_ready), 1);

    // 5: ce gap mid-neuron, pop while ce low
    bus.out_ready = 1'b0;
    issue(16, 1'b1);
    repeat (6) step();
    check("t5_held", int'(bus.out_data), 1);
    issue(10, 1'b0);
    issue(20, 1'b0);
    bus.ce        = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("t5_pop_ce0", int'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    step();
    step();
    bus.ce = 1'b1;
    issue(30, 1'b0);
    issue(40, 1'b1);
    bus.out_ready = 1'b1;
    wait_valid(n);
    check("t5_lat", n, 4);
    check("t5_data", int'(bus.out_data), 6);
    step();
    check("t5_pop", int'(bus.out_valid), 0);

    // 6: reset mid-neuron, then 16+16 -> 2
    issue(100, 1'b0);
    issue(200, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_valid", int'(bus.out_valid), 0);
    check("t6_rst_ready", int'(bus.in_ready), 1);
    issue(16, 1'b0);
    issue(16, 1'b1);
    wait_valid(n);
    check("t6_lat", n, 4);
    check("t6_data", int'(bus.out_data), 2);
    step();
    repeat (6) step();
    check("t6_nostale", int'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
